// File: rtl/weight_medium_arbiter.sv
// weight_medium_arbiter
// Round-robin arbiter sharing one weight_medium (a wide word store built
// from PIECES narrow BRAM beats) between REQUESTERS clients. The winner's
// command is captured, a single-cycle enable is issued to the medium, and
// completion plus read data are returned once the medium reports finished.
// Only one medium transaction is ever outstanding.
//
// Optional feature: define WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN to add the
// TIMEOUT_CYCLES parameter and the sticky timeout_out flag, which bound the
// wait for med_finished_in. Without it the wait is unbounded.
module weight_medium_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int ADDRS      = 256,
    parameter int BRAM_WIDTH = 64,
    parameter int PIECES     = 48,
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 4096,
`endif
    localparam int ADDR_SIZE = $clog2(ADDRS),
    localparam int WIDTH     = PIECES * BRAM_WIDTH
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [REQUESTERS-1:0]           req_read_in,
    input  logic [REQUESTERS-1:0]           req_write_in,
    input  logic [REQUESTERS*ADDR_SIZE-1:0] req_addr_in,
    input  logic [REQUESTERS*WIDTH-1:0]     req_weight_in,
    output logic [REQUESTERS-1:0]           req_ack_out,
    output logic [REQUESTERS-1:0]           req_done_out,
    output logic [WIDTH-1:0]                weight_out,
    output logic                            busy_out,
    output logic [ADDR_SIZE-1:0]            med_addr_out,
    output logic [WIDTH-1:0]                med_weight_out,
    output logic                            med_read_enable,
    output logic                            med_write_enable,
    input  logic [WIDTH-1:0]                med_weight_in,
    input  logic                            med_finished_in
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
    ,
    output logic                            timeout_out
`endif
);

    // Index width for client numbers; one extra bit lets the rotating
    // search add an offset to the pointer before wrapping.
    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CW    = IDX_W + 1;

`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant_q;
    logic                    op_write_q;

    logic [REQUESTERS-1:0]   pending;
    logic                    grant_found;
    logic [IDX_W-1:0]        grant_idx;
    logic [CW-1:0]           cand;
    logic [REQUESTERS-1:0]   grant_onehot;
    logic [REQUESTERS-1:0]   owner_onehot;

    logic                    sel_write;
    logic [ADDR_SIZE-1:0]    sel_addr;
    logic [WIDTH-1:0]        sel_weight;

`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
    logic [TW-1:0]           wait_cnt;
`endif

    // A client competes whenever it holds either request line.
    always_comb begin
        pending = req_read_in | req_write_in;
    end

    // Rotating priority search: first pending client after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= REQUESTERS; off++) begin
            cand = {1'b0, rr_ptr} + CW'(off);
            if (cand >= CW'(REQUESTERS)) begin
                cand = cand - CW'(REQUESTERS);
            end
            if (!grant_found && pending[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Select the candidate winner's command, address and write data.
    always_comb begin
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_weight = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_write  = req_write_in[i];
                sel_addr   = req_addr_in[i*ADDR_SIZE +: ADDR_SIZE];
                sel_weight = req_weight_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot forms of the fresh grant (for ack) and the captured owner (for done).
    always_comb begin
        grant_onehot = '0;
        owner_onehot = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_onehot[i] = 1'b1;
            end
            if (grant_q == IDX_W'(i)) begin
                owner_onehot[i] = 1'b1;
            end
        end
    end

    // Transaction sequencer: arbitrate, issue one enable, wait for the medium, report done.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            rr_ptr           <= IDX_W'(REQUESTERS - 1);
            grant_q          <= '0;
            op_write_q       <= 1'b0;
            req_ack_out      <= '0;
            req_done_out     <= '0;
            weight_out       <= '0;
            busy_out         <= 1'b0;
            med_addr_out     <= '0;
            med_weight_out   <= '0;
            med_read_enable  <= 1'b0;
            med_write_enable <= 1'b0;
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
            wait_cnt         <= '0;
            timeout_out      <= 1'b0;
`endif
        end else begin
            req_ack_out      <= '0;
            req_done_out     <= '0;
            med_read_enable  <= 1'b0;
            med_write_enable <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_found) begin
                        req_ack_out    <= grant_onehot;
                        grant_q        <= grant_idx;
                        rr_ptr         <= grant_idx;
                        op_write_q     <= sel_write;
                        med_addr_out   <= sel_addr;
                        med_weight_out <= sel_weight;
                        busy_out       <= 1'b1;
                        state          <= ISSUE;
                    end
                end

                ISSUE: begin
                    med_write_enable <= op_write_q;
                    med_read_enable  <= !op_write_q;
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
                    wait_cnt         <= '0;
`endif
                    state            <= WAIT;
                end

                WAIT: begin
                    if (med_finished_in) begin
                        if (!op_write_q) begin
                            weight_out <= med_weight_in;
                        end
                        req_done_out <= owner_onehot;
                        state        <= DONE;
                    end
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_out  <= 1'b1;
                        req_done_out <= owner_onehot;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_medium_arbiter.sv
// tb_weight_medium_arbiter
// Directed bench for weight_medium_arbiter with a behavioural medium model
// that answers each enable after a programmable latency.
module tb_weight_medium_arbiter;

    localparam int REQUESTERS = 2;
    localparam int ADDRS      = 256;
    localparam int BRAM_WIDTH = 64;
    localparam int PIECES     = 48;
    localparam int ADDR_SIZE  = 8;
    localparam int WIDTH      = PIECES * BRAM_WIDTH;

    localparam logic [WIDTH-1:0] PAT_A5 = {(WIDTH/8){8'hA5}};
    localparam logic [WIDTH-1:0] PAT_5A = {(WIDTH/8){8'h5A}};
    localparam logic [WIDTH-1:0] PAT_3C = {(WIDTH/8){8'h3C}};

    logic                            clk_in;
    logic                            rst_in;
    logic [REQUESTERS-1:0]           req_read_in;
    logic [REQUESTERS-1:0]           req_write_in;
    logic [REQUESTERS*ADDR_SIZE-1:0] req_addr_in;
    logic [REQUESTERS*WIDTH-1:0]     req_weight_in;
    logic [REQUESTERS-1:0]           req_ack_out;
    logic [REQUESTERS-1:0]           req_done_out;
    logic [WIDTH-1:0]                weight_out;
    logic                            busy_out;
    logic [ADDR_SIZE-1:0]            med_addr_out;
    logic [WIDTH-1:0]                med_weight_out;
    logic                            med_read_enable;
    logic                            med_write_enable;
    logic [WIDTH-1:0]                med_weight_in;
    logic                            med_finished_in;
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
    logic                            timeout_out;
    logic                            timeout_at_done;
`endif

    int checks = 0;
    int errors = 0;

    // Medium model and event monitor state
    logic [WIDTH-1:0]     mem [0:ADDRS-1];
    int                   cyc = 0;
    int                   lat = 4;
    bit                   hold = 0;
    int                   countdown = 0;
    bit                   outstanding = 0;
    logic [ADDR_SIZE-1:0] paddr = '0;
    int                   ack_cnt [REQUESTERS];
    int                   done_cnt [REQUESTERS];
    int                   last_ack_cyc = -1, last_ack_idx = -1;
    int                   last_done_cyc = -1, last_done_idx = -1;
    int                   last_en_cyc = -1, fin_cyc = -1;
    logic [ADDR_SIZE-1:0] last_en_addr = '0;
    int                   wen_cnt = 0, ren_cnt = 0;
    int                   both_en_err = 0, overlap_err = 0;
    logic [WIDTH-1:0]     weight_at_done = '0;
    int                   grant_log [$];

    weight_medium_arbiter #(
        .REQUESTERS(REQUESTERS),
        .ADDRS(ADDRS),
        .BRAM_WIDTH(BRAM_WIDTH),
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .PIECES(PIECES)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_read_in(req_read_in),
        .req_write_in(req_write_in),
        .req_addr_in(req_addr_in),
        .req_weight_in(req_weight_in),
        .req_ack_out(req_ack_out),
        .req_done_out(req_done_out),
        .weight_out(weight_out),
        .busy_out(busy_out),
        .med_addr_out(med_addr_out),
        .med_weight_out(med_weight_out),
        .med_read_enable(med_read_enable),
        .med_write_enable(med_write_enable),
        .med_weight_in(med_weight_in),
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
        .timeout_out(timeout_out),
`endif
        .med_finished_in(med_finished_in)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Medium model plus monitor, sampling just after each rising edge
    initial begin
        med_finished_in = 1'b0;
        med_weight_in   = '0;
        for (int i = 0; i < ADDRS; i++) mem[i] = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            ack_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (med_finished_in) med_finished_in = 1'b0;
            if (!rst_in) begin
                countdown   = 0;
                outstanding = 0;
            end else begin
                for (int i = 0; i < REQUESTERS; i++) begin
                    if (req_ack_out[i]) begin
                        ack_cnt[i]++;
                        last_ack_cyc = cyc;
                        last_ack_idx = i;
                        grant_log.push_back(i);
                    end
                    if (req_done_out[i]) begin
                        done_cnt[i]++;
                        last_done_cyc  = cyc;
                        last_done_idx  = i;
                        weight_at_done = weight_out;
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
                        timeout_at_done = timeout_out;
`endif
                    end
                end
                if (med_read_enable && med_write_enable) both_en_err++;
                if (med_read_enable || med_write_enable) begin
                    if (outstanding) overlap_err++;
                    outstanding  = 1;
                    last_en_cyc  = cyc;
                    last_en_addr = med_addr_out;
                    paddr        = med_addr_out;
                    countdown    = lat;
                    if (med_write_enable) begin
                        wen_cnt++;
                        mem[med_addr_out] = med_weight_out;
                    end else begin
                        ren_cnt++;
                    end
                end else if (countdown > 0 && !hold) begin
                    countdown--;
                    if (countdown == 0) begin
                        med_finished_in = 1'b1;
                        med_weight_in   = mem[paddr];
                        fin_cyc         = cyc;
                        outstanding     = 0;
                    end
                end
            end
        end
    end

    task automatic wait_ack(input int idx, input int budget, output bit ok);
        int start = ack_cnt[idx];
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_in);
            if (ack_cnt[idx] != start) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int idx, input int budget, output bit ok);
        int start = done_cnt[idx];
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_in);
            if (done_cnt[idx] != start) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic clear_requests();
        req_read_in   = '0;
        req_write_in  = '0;
        req_addr_in   = '0;
        req_weight_in = '0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        clear_requests();
        repeat (3) @(negedge clk_in);
        checks++; if (req_ack_out !== '0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", req_ack_out); end
        checks++; if (req_done_out !== '0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", req_done_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_out); end
        checks++; if (weight_out !== '0) begin errors++; $display("[TB] FAIL reset_weight: got %h expected 0", weight_out[31:0]); end
        checks++; if ({med_read_enable, med_write_enable} !== 2'b00) begin errors++; $display("[TB] FAIL reset_enables: got %b expected 00", {med_read_enable, med_write_enable}); end
        checks++; if (med_addr_out !== '0 || med_weight_out !== '0) begin errors++; $display("[TB] FAIL reset_med_bus: got addr %0d expected 0", med_addr_out); end
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
        checks++; if (timeout_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_out); end
`endif
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_write();
        bit ok;
        int a, w0, r0;
        lat = 100;
        w0 = wen_cnt; r0 = ren_cnt;
        req_write_in[0]          = 1'b1;
        req_addr_in[0 +: 8]      = 8'd5;
        req_weight_in[0 +: WIDTH] = PAT_A5;
        wait_ack(0, 10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL write_ack_timeout: got none expected ack[0]"); end
        a = last_ack_cyc;
        checks++; if (busy_out !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_at_ack: got %b expected 1", busy_out); end
        clear_requests();
        wait_done(0, 150, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL write_done_timeout: got none expected done[0]"); end
        checks++; if (last_en_cyc !== a + 1) begin errors++; $display("[TB] FAIL write_enable_cycle: got %0d expected %0d", last_en_cyc, a + 1); end
        checks++; if (last_en_addr !== 8'd5) begin errors++; $display("[TB] FAIL write_addr: got %0d expected 5", last_en_addr); end
        checks++; if (wen_cnt - w0 !== 1 || ren_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL write_enable_count: got w%0d r%0d expected w1 r0", wen_cnt - w0, ren_cnt - r0); end
        checks++; if (fin_cyc !== last_en_cyc + 100) begin errors++; $display("[TB] FAIL write_latency: got %0d expected %0d", fin_cyc, last_en_cyc + 100); end
        checks++; if (last_done_cyc !== fin_cyc + 1) begin errors++; $display("[TB] FAIL write_done_cycle: got %0d expected %0d", last_done_cyc, fin_cyc + 1); end
        checks++; if (mem[5] !== PAT_A5) begin errors++; $display("[TB] FAIL write_data: got %h expected %h", mem[5][31:0], PAT_A5[31:0]); end
        checks++; if (weight_out !== '0) begin errors++; $display("[TB] FAIL write_weight_untouched: got %h expected 0", weight_out[31:0]); end
        @(negedge clk_in);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after: got %b expected 0", busy_out); end
    endtask

    task automatic test_read();
        bit ok;
        int w0, r0;
        lat = 5;
        w0 = wen_cnt; r0 = ren_cnt;
        req_read_in[1]      = 1'b1;
        req_addr_in[8 +: 8] = 8'd5;
        wait_ack(1, 10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL read_ack_timeout: got none expected ack[1]"); end
        clear_requests();
        wait_done(1, 30, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL read_done_timeout: got none expected done[1]"); end
        checks++; if (weight_at_done !== PAT_A5) begin errors++; $display("[TB] FAIL read_data_at_done: got %h expected %h", weight_at_done[31:0], PAT_A5[31:0]); end
        checks++; if (ren_cnt - r0 !== 1 || wen_cnt - w0 !== 0) begin errors++; $display("[TB] FAIL read_enable_count: got r%0d w%0d expected r1 w0", ren_cnt - r0, wen_cnt - w0); end
        checks++; if (last_done_idx !== 1) begin errors++; $display("[TB] FAIL read_done_idx: got %0d expected 1", last_done_idx); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
        lat = 3;
        grant_log.delete();
        d0 = done_cnt[0] + done_cnt[1];
        req_read_in[0]             = 1'b1;
        req_addr_in[0 +: 8]        = 8'd10;
        req_write_in[1]            = 1'b1;
        req_addr_in[8 +: 8]        = 8'd11;
        req_weight_in[WIDTH +: WIDTH] = PAT_5A;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (grant_log.size() >= 6) break;
        end
        clear_requests();
        checks++; if (grant_log.size() != 6) begin errors++; $display("[TB] FAIL b2b_grant_count: got %0d expected 6", grant_log.size()); end
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (done_cnt[0] + done_cnt[1] - d0 == 6) begin ok = 1; break; end
            @(negedge clk_in);
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 6", done_cnt[0] + done_cnt[1] - d0); end
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) begin
                checks++; if (grant_log[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL b2b_grant_%0d: got %0d expected %0d", i, grant_log[i], exp_seq[i]); end
            end
        end
        checks++; if (both_en_err !== 0) begin errors++; $display("[TB] FAIL b2b_dual_enable: got %0d expected 0", both_en_err); end
        checks++; if (overlap_err !== 0) begin errors++; $display("[TB] FAIL b2b_overlap: got %0d expected 0", overlap_err); end
        checks++; if (mem[11] !== PAT_5A) begin errors++; $display("[TB] FAIL b2b_write_data: got %h expected %h", mem[11][31:0], PAT_5A[31:0]); end
    endtask

    task automatic test_read_write_both();
        bit ok;
        int w0, r0, dn0;
        lat = 4;
        w0 = wen_cnt; r0 = ren_cnt; dn0 = done_cnt[0];
        req_read_in[0]            = 1'b1;
        req_write_in[0]           = 1'b1;
        req_addr_in[0 +: 8]       = 8'd7;
        req_weight_in[0 +: WIDTH] = PAT_3C;
        wait_ack(0, 10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rw_ack_timeout: got none expected ack[0]"); end
        clear_requests();
        wait_done(0, 30, ok);
        repeat (5) @(negedge clk_in);
        checks++; if (wen_cnt - w0 !== 1 || ren_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL rw_enable_count: got w%0d r%0d expected w1 r0", wen_cnt - w0, ren_cnt - r0); end
        checks++; if (done_cnt[0] - dn0 !== 1) begin errors++; $display("[TB] FAIL rw_done_count: got %0d expected 1", done_cnt[0] - dn0); end
        checks++; if (last_en_addr !== 8'd7 || mem[7] !== PAT_3C) begin errors++; $display("[TB] FAIL rw_write: got addr %0d data %h expected addr 7 data %h", last_en_addr, mem[7][31:0], PAT_3C[31:0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dsum;
        hold = 1;
        req_read_in[1]      = 1'b1;
        req_addr_in[8 +: 8] = 8'd5;
        wait_ack(1, 10, ok);
        clear_requests();
        repeat (3) @(negedge clk_in);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy_in_wait: got %b expected 1", busy_out); end
        dsum = done_cnt[0] + done_cnt[1];
        #2 rst_in = 1'b0;
        #1;
        checks++; if (busy_out !== 1'b0 || med_addr_out !== '0 || weight_out !== '0) begin errors++; $display("[TB] FAIL rmid_async_clear: got busy %b addr %0d expected 0 0", busy_out, med_addr_out); end
        repeat (3) @(negedge clk_in);
        hold = 0;
        rst_in = 1'b1;
        checks++; if (done_cnt[0] + done_cnt[1] !== dsum) begin errors++; $display("[TB] FAIL rmid_no_done: got %0d expected %0d", done_cnt[0] + done_cnt[1], dsum); end
        lat = 2;
        req_read_in[1]      = 1'b1;
        req_addr_in[8 +: 8] = 8'd5;
        wait_ack(1, 10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_regrant: got none expected ack[1]"); end
        clear_requests();
        wait_done(1, 30, ok);
        checks++; if (!ok || weight_at_done !== PAT_A5) begin errors++; $display("[TB] FAIL rmid_read_after: got %h expected %h", weight_at_done[31:0], PAT_A5[31:0]); end
    endtask

    task automatic test_stray_finished();
        logic [WIDTH-1:0] w;
        int dsum;
        @(negedge clk_in);
        w = weight_out;
        dsum = done_cnt[0] + done_cnt[1];
        med_weight_in   = PAT_3C;
        med_finished_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (busy_out !== 1'b0 || done_cnt[0] + done_cnt[1] !== dsum) begin errors++; $display("[TB] FAIL stray_finished_state: got busy %b expected 0", busy_out); end
        checks++; if (weight_out !== w) begin errors++; $display("[TB] FAIL stray_finished_weight: got %h expected %h", weight_out[31:0], w[31:0]); end
    endtask

`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        logic [WIDTH-1:0] w;
        w = weight_out;
        hold = 1;
        req_read_in[0]      = 1'b1;
        req_addr_in[0 +: 8] = 8'd5;
        wait_ack(0, 10, ok);
        clear_requests();
        wait_done(0, 40, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL to_done_timeout: got none expected done[0]"); end
        checks++; if (last_done_cyc !== last_en_cyc + 16) begin errors++; $display("[TB] FAIL to_done_cycle: got %0d expected %0d", last_done_cyc, last_en_cyc + 16); end
        checks++; if (timeout_at_done !== 1'b1) begin errors++; $display("[TB] FAIL to_flag: got %b expected 1", timeout_at_done); end
        checks++; if (weight_at_done !== w) begin errors++; $display("[TB] FAIL to_weight_kept: got %h expected %h", weight_at_done[31:0], w[31:0]); end
        hold = 0; outstanding = 0; countdown = 0;
        lat = 3;
        req_write_in[1]               = 1'b1;
        req_addr_in[8 +: 8]           = 8'd20;
        req_weight_in[WIDTH +: WIDTH] = PAT_5A;
        wait_ack(1, 10, ok);
        clear_requests();
        wait_done(1, 30, ok);
        checks++; if (!ok || timeout_out !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky: got %b expected 1", timeout_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid();
        test_stray_finished();
`ifdef WEIGHT_MEDIUM_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
